// File: rtl/gold_fall_scheduler.sv
// Per-frame gold bag fall arbiter: probes the dirt tile under bags A and B through
// the single-port dirt memory, then steps each bag's REST/WOBBLE/FALL machine.
module gold_fall_scheduler #(
  parameter logic [10:0] BOARD_X       = 11'd32,
  parameter logic [10:0] BOARD_Y       = 11'd160,
  parameter int          BOARD_COLS    = 15,
  parameter int          BOARD_ROWS    = 10,
  parameter int          WOBBLE_FRAMES = 8,
  parameter int          PROBE_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startOfFrame,
  input  logic [10:0] goldTLX_a,
  input  logic [10:0] goldTLY_a,
  input  logic [10:0] goldTLX_b,
  input  logic [10:0] goldTLY_b,
  input  logic        eaten_a,
  input  logic        eaten_b,
  output logic        probe_req,
  output logic [3:0]  probe_col,
  output logic [3:0]  probe_row,
  input  logic        probe_ack,
  input  logic        probe_empty,
  output logic        can_fall_a,
  output logic        can_fall_b,
  output logic        wobble_a,
  output logic        wobble_b,
  output logic        frame_overrun
);

  localparam int TW = $clog2(PROBE_TIMEOUT);

  typedef enum logic [1:0] {SEQ_IDLE, SEQ_PROBE_A, SEQ_PROBE_B, SEQ_UPDATE} seq_state_t;
  typedef enum logic [1:0] {BAG_REST, BAG_WOBBLE, BAG_FALL} bag_state_t;

  if (WOBBLE_FRAMES < 1 || WOBBLE_FRAMES > 15 || PROBE_TIMEOUT < 2 ||
      BOARD_COLS < 1 || BOARD_COLS > 16 || BOARD_ROWS < 1 || BOARD_ROWS > 16) begin : g_bad_params
    $error("gold_fall_scheduler: parameter out of range");
  end

  logic [10:0] w_tlx [2];
  logic [10:0] w_tly [2];
  logic        w_eaten_in [2];
  logic [3:0]  w_col [2];
  logic [10:0] w_row_full [2];
  logic        w_skip_in [2];

  assign w_tlx[0]      = goldTLX_a;
  assign w_tlx[1]      = goldTLX_b;
  assign w_tly[0]      = goldTLY_a;
  assign w_tly[1]      = goldTLY_b;
  assign w_eaten_in[0] = eaten_a;
  assign w_eaten_in[1] = eaten_b;

  // Row targets the tile just below the bag's bottom edge (one tile = 32 px).
  for (genvar gi = 0; gi < 2; gi++) begin : g_tile
    assign w_col[gi]      = 4'((w_tlx[gi] - BOARD_X) >> 5);
    assign w_row_full[gi] = (w_tly[gi] - BOARD_Y + 11'd32) >> 5;
    assign w_skip_in[gi]  = w_eaten_in[gi] || (w_row_full[gi] >= 11'(BOARD_ROWS));
  end

  seq_state_t r_state, w_state_next;
  logic          r_probe_req;
  logic [TW-1:0] r_timer;
  logic [3:0]    r_col [2];
  logic [3:0]    r_row [2];
  logic          r_eaten [2];
  logic          r_below [2];
  logic          r_skip_b;
  logic          r_overrun;

  logic w_sel_b, w_ack_hit, w_timeout, w_probe_done;

  assign w_sel_b      = (r_state == SEQ_PROBE_B);
  assign w_ack_hit    = r_probe_req && probe_ack;
  assign w_timeout    = r_probe_req && !probe_ack && (r_timer == TW'(PROBE_TIMEOUT - 1));
  assign w_probe_done = w_ack_hit || w_timeout;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      SEQ_IDLE: begin
        if (startOfFrame) begin
          if (!w_skip_in[0])      w_state_next = SEQ_PROBE_A;
          else if (!w_skip_in[1]) w_state_next = SEQ_PROBE_B;
          else                    w_state_next = SEQ_UPDATE;
        end
      end
      SEQ_PROBE_A: if (w_probe_done) w_state_next = r_skip_b ? SEQ_UPDATE : SEQ_PROBE_B;
      SEQ_PROBE_B: if (w_probe_done) w_state_next = SEQ_UPDATE;
      default:     w_state_next = SEQ_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= SEQ_IDLE;
      r_probe_req <= 1'b0;
      r_timer     <= '0;
      r_skip_b    <= 1'b0;
      r_overrun   <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        r_col[i]   <= 4'd0;
        r_row[i]   <= 4'd0;
        r_eaten[i] <= 1'b0;
        r_below[i] <= 1'b0;
      end
    end else begin
      r_state   <= w_state_next;
      r_overrun <= startOfFrame && (r_state != SEQ_IDLE);
      if (r_state == SEQ_IDLE && startOfFrame) begin
        r_skip_b <= w_skip_in[1];
        for (int i = 0; i < 2; i++) begin
          r_col[i]   <= w_col[i];
          r_row[i]   <= w_row_full[i][3:0];
          r_eaten[i] <= w_eaten_in[i];
          r_below[i] <= 1'b0;
        end
      end
      // First probe cycle is a request-low gap so back-to-back probes never merge.
      if (r_state == SEQ_PROBE_A || r_state == SEQ_PROBE_B) begin
        if (!r_probe_req) begin
          r_probe_req <= 1'b1;
          r_timer     <= '0;
        end else if (w_probe_done) begin
          r_probe_req      <= 1'b0;
          r_below[w_sel_b] <= w_ack_hit && probe_empty;
        end else begin
          r_timer <= r_timer + 1'b1;
        end
      end
    end
  end

  assign probe_req     = r_probe_req;
  assign probe_col     = r_probe_req ? (w_sel_b ? r_col[1] : r_col[0]) : 4'd0;
  assign probe_row     = r_probe_req ? (w_sel_b ? r_row[1] : r_row[0]) : 4'd0;
  assign frame_overrun = r_overrun;

  logic w_fall [2];
  logic w_wobble [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_bag
    bag_state_t r_bag, w_bag_next;
    logic [3:0] r_cnt, w_cnt_next;

    always_comb begin
      w_bag_next = r_bag;
      w_cnt_next = r_cnt;
      if (r_state == SEQ_UPDATE) begin
        if (r_eaten[gi]) begin
          w_bag_next = BAG_REST;
          w_cnt_next = 4'd0;
        end else begin
          case (r_bag)
            BAG_REST: begin
              if (r_below[gi]) begin
                w_bag_next = BAG_WOBBLE;
                w_cnt_next = 4'd1;
              end
            end
            BAG_WOBBLE: begin
              if (!r_below[gi]) begin
                w_bag_next = BAG_REST;
                w_cnt_next = 4'd0;
              end else if (r_cnt == 4'(WOBBLE_FRAMES)) begin
                w_bag_next = BAG_FALL;
                w_cnt_next = 4'd0;
              end else begin
                w_cnt_next = r_cnt + 4'd1;
              end
            end
            BAG_FALL: begin
              if (!r_below[gi]) w_bag_next = BAG_REST;
            end
            default: begin
              w_bag_next = BAG_REST;
              w_cnt_next = 4'd0;
            end
          endcase
        end
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        r_bag <= BAG_REST;
        r_cnt <= 4'd0;
      end else begin
        r_bag <= w_bag_next;
        r_cnt <= w_cnt_next;
      end
    end

    assign w_fall[gi]   = (r_bag == BAG_FALL);
    assign w_wobble[gi] = (r_bag == BAG_WOBBLE);
  end

  assign can_fall_a = w_fall[0];
  assign can_fall_b = w_fall[1];
  assign wobble_a   = w_wobble[0];
  assign wobble_b   = w_wobble[1];

endmodule

// File: tb/tb_gold_fall_scheduler.sv
// Bench for gold_fall_scheduler: frame table with scoreboarded outputs and probes,
// plus reset-mid-probe, overrun and ack-timeout sequences.
module tb_gold_fall_scheduler;

  logic        clk = 1'b0;
  logic        reset, startOfFrame;
  logic [10:0] goldTLX_a, goldTLY_a, goldTLX_b, goldTLY_b;
  logic        eaten_a, eaten_b;
  logic        probe_req, probe_ack, probe_empty;
  logic [3:0]  probe_col, probe_row;
  logic        can_fall_a, can_fall_b, wobble_a, wobble_b, frame_overrun;

  gold_fall_scheduler dut (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame),
    .goldTLX_a(goldTLX_a), .goldTLY_a(goldTLY_a),
    .goldTLX_b(goldTLX_b), .goldTLY_b(goldTLY_b),
    .eaten_a(eaten_a), .eaten_b(eaten_b),
    .probe_req(probe_req), .probe_col(probe_col), .probe_row(probe_row),
    .probe_ack(probe_ack), .probe_empty(probe_empty),
    .can_fall_a(can_fall_a), .can_fall_b(can_fall_b),
    .wobble_a(wobble_a), .wobble_b(wobble_b), .frame_overrun(frame_overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] col;
    logic [3:0] row;
    logic       empty;
  } probe_t;

  typedef struct {
    int          reps;
    logic [10:0] xa, ya, xb, yb;
    logic        ea, eb, empa, empb, sof2;
    logic [3:0]  exp;   // {wobble_a, can_fall_a, wobble_b, can_fall_b}
  } vec_t;

  localparam logic [10:0] AX = 11'd192, AY = 11'd192;
  localparam logic [10:0] BX = 11'd256, BY3 = 11'd224, BY9 = 11'd416, BY10 = 11'd448;

  int       n_cmp = 0;
  int       n_bad = 0;
  bit       ack_en = 1'b1;
  int       ack_cnt = 0;
  probe_t   pq [$];
  logic [3:0] sb [$];
  vec_t     tbl [13];
  int       frame_no = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (frame %0d): got %0h expected %0h", name, frame_no, act, exp);
    end
  endtask

  function automatic logic [10:0] row_of(input logic [10:0] y);
    return (y - 11'd160 + 11'd32) >> 5;
  endfunction

  function automatic logic [3:0] col_of(input logic [10:0] x);
    return 4'((x - 11'd32) >> 5);
  endfunction

  // Dirt-memory responder: acks one cycle after it first sees a request.
  initial begin
    probe_t p;
    probe_ack   = 1'b0;
    probe_empty = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (probe_ack) begin
        probe_ack = 1'b0;
        ack_cnt   = 0;
      end else if (probe_req && ack_en) begin
        if (ack_cnt >= 1) begin
          probe_ack = 1'b1;
          ack_cnt   = 0;
          check("probe_expected", 32'(pq.size() != 0), 1);
          if (pq.size() != 0) begin
            p = pq.pop_front();
            check("probe_col", probe_col, p.col);
            check("probe_row", probe_row, p.row);
            probe_empty = p.empty;
            $display("probe col=%0d row=%0d empty=%0b", probe_col, probe_row, p.empty);
          end else begin
            probe_empty = 1'b0;
          end
        end else begin
          ack_cnt++;
        end
      end else begin
        ack_cnt = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic pulse_sof();
    startOfFrame = 1'b1;
    @(posedge clk); #1;
    startOfFrame = 1'b0;
  endtask

  task automatic run_frame(input vec_t v);
    logic [10:0] ra, rb;
    logic [3:0]  e;
    bit          found;
    frame_no++;
    goldTLX_a = v.xa; goldTLY_a = v.ya; goldTLX_b = v.xb; goldTLY_b = v.yb;
    eaten_a = v.ea; eaten_b = v.eb;
    ra = row_of(v.ya);
    rb = row_of(v.yb);
    if (!v.ea && ra < 11'd10) pq.push_back('{col_of(v.xa), ra[3:0], v.empa});
    if (!v.eb && rb < 11'd10) pq.push_back('{col_of(v.xb), rb[3:0], v.empb});
    sb.push_back(v.exp);
    pulse_sof();
    if (v.sof2) begin
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
        @(posedge clk); #1;
        found = probe_req && (probe_row == rb[3:0]);
      end
      check("sof2_wait_probe_b", 32'(found), 1);
      if (found) begin
        pulse_sof();
        check("overrun_pulse", frame_overrun, 1);
        @(posedge clk); #1;
        check("overrun_clear", frame_overrun, 0);
      end
    end
    repeat (40) @(posedge clk);
    #1;
    e = sb.pop_front();
    $display("frame %0d: wob_a=%0b fall_a=%0b wob_b=%0b fall_b=%0b (exp %4b)",
             frame_no, wobble_a, can_fall_a, wobble_b, can_fall_b, e);
    check("wobble_a", wobble_a, e[3]);
    check("can_fall_a", can_fall_a, e[2]);
    check("wobble_b", wobble_b, e[1]);
    check("can_fall_b", can_fall_b, e[0]);
    check("no_overrun", frame_overrun, 0);
    check("probes_outstanding", pq.size(), 0);
    pq.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int  run;
    int  runs [$];
    bit  found;
    vec_t v;

    tbl[0]  = '{8, AX, AY, BX, BY3,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b1010};
    tbl[1]  = '{2, AX, AY, BX, BY3,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0101};
    tbl[2]  = '{1, AX, AY, BX, BY9,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0101};
    tbl[3]  = '{1, AX, AY, BX, BY10, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0100};
    tbl[4]  = '{1, AX, AY, BX, BY3,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000};
    tbl[5]  = '{3, AX, AY, BX, BY3,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1000};
    tbl[6]  = '{1, AX, AY, BX, BY3,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000};
    tbl[7]  = '{8, AX, AY, BX, BY3,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1000};
    tbl[8]  = '{2, AX, AY, BX, BY3,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0100};
    tbl[9]  = '{1, AX, AY, BX, BY3,  1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0000};
    tbl[10] = '{1, AX, AY, BX, BY3,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000};
    tbl[11] = '{1, AX, AY, BX, BY3,  1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000};
    tbl[12] = '{1, AX, AY, BX, BY3,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1000};

    startOfFrame = 1'b0;
    goldTLX_a = AX; goldTLY_a = AY; goldTLX_b = BX; goldTLY_b = BY3;
    eaten_a = 1'b0; eaten_b = 1'b0;
    do_reset();
    check("rst_probe_req", probe_req, 0);
    check("rst_probe_col", probe_col, 0);
    check("rst_probe_row", probe_row, 0);
    check("rst_can_fall_a", can_fall_a, 0);
    check("rst_can_fall_b", can_fall_b, 0);
    check("rst_wobble_a", wobble_a, 0);
    check("rst_wobble_b", wobble_b, 0);
    check("rst_overrun", frame_overrun, 0);

    for (int r = 0; r < 13; r++)
      for (int k = 0; k < tbl[r].reps; k++)
        run_frame(tbl[r]);

    // Reset while bag A's probe is in flight (A currently wobbling).
    frame_no++;
    pulse_sof();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk); #1;
      found = probe_req;
    end
    check("midprobe_req_seen", 32'(found), 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    $display("reset mid-probe: req=%0b wob_a=%0b", probe_req, wobble_a);
    check("midrst_probe_req", probe_req, 0);
    check("midrst_wobble_a", wobble_a, 0);
    check("midrst_can_fall_a", can_fall_a, 0);
    check("midrst_overrun", frame_overrun, 0);
    check("midrst_probe_col", probe_col, 0);
    pq.delete();
    v = '{1, AX, AY, BX, BY3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1000};
    run_frame(v);

    // Memory never acks: each probe times out after 16 request cycles.
    ack_en = 1'b0;
    do_reset();
    frame_no++;
    pulse_sof();
    run = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (probe_req) run++;
      else if (run > 0) begin
        runs.push_back(run);
        run = 0;
      end
    end
    $display("timeout frame: %0d request pulses", runs.size());
    check("timeout_pulse_count", runs.size(), 2);
    if (runs.size() >= 2) begin
      check("timeout_len_a", runs[0], 16);
      check("timeout_len_b", runs[1], 16);
    end
    check("timeout_wobble_a", wobble_a, 0);
    check("timeout_wobble_b", wobble_b, 0);
    check("timeout_can_fall_a", can_fall_a, 0);
    pulse_sof();
    check("timeout_back_idle", frame_overrun, 0);
    repeat (45) @(posedge clk);
    #1;
    check("timeout2_wobble_a", wobble_a, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
